aes_key_sched_stream: RTL and testbench
=======================================

# aes_key_sched_stream

Sequential AES-128 key schedule feeding round keys to the round datapath (`encryptRound` / `decryptRound`).
- Accepts a 128-bit cipher key and expands it at one round key per cycle into an internal 11×128 bank.
- Streams the round keys over a valid/ready port, in encrypt order (0→10) or decrypt order (10→0).
- Retains the bank so the same key can be replayed without re-expansion.

## Interface
Parameters: none (AES-128 fixed: Nk=4, Nr=10).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_in` in 128: cipher key; byte 0 in `[127:120]` (FIPS-197 order).
- `key_valid` in 1: `key_in` and `dir` valid.
- `key_ready` out 1: key can be accepted.
- `dir` in 1: 0 = encrypt order, 1 = decrypt order; sampled at key accept or replay accept.
- `replay` in 1: restream the stored bank in the order given by `dir`.
- `rk_data` out 128: current round key.
- `rk_idx` out 4: round number of `rk_data` (0..10).
- `rk_valid` out 1: `rk_data` valid.
- `rk_ready` in 1: consumer accepts the beat.
- `rk_last` out 1: final beat of the stream.
- `keys_held` out 1: bank holds a completely expanded key.

## Operation
States: IDLE, EXPAND, STREAM.

IDLE
- `key_ready`=1.
- Key accept (`key_valid`&&`key_ready`): write `key_in` to rk[0], latch `dir`, clear round counter r=1 and `keys_held`, go to EXPAND.
- `replay`=1 && `keys_held`=1 && `key_valid`=0: latch `dir`, go to STREAM.
- `key_valid` has priority over `replay` on the same cycle.
- `replay` is ignored when `keys_held`=0.

EXPAND
- `key_ready`=0.
- Each cycle: rk[r] = f(rk[r-1], Rcon[r]), using standard AES-128 word recurrence.
  - SubWord uses four forward S-box instances.
  - RotWord is a left byte rotation.
  - Rcon = 01,02,04,08,10,20,40,80,1b,36.
- r increments each cycle. After r=10 is written: set `keys_held`=1, go to STREAM.

STREAM
- `key_ready`=0; `key_valid` and `replay` are ignored.
- Pointer p starts at 0 (dir=0) or 10 (dir=1).
- `rk_valid`=1, `rk_data`=rk[p], `rk_idx`=p.
- `rk_last`=1 when p=10 (dir=0) or p=0 (dir=1).
- On a handshake, p steps +1 or −1.
- On the handshake with `rk_last`=1, go to IDLE.
- While `rk_valid`&&!`rk_ready`: `rk_data`, `rk_idx` and `rk_last` hold stable.

Reset
- `rst` in any state goes to IDLE and clears r, p, `dir`, `keys_held`.
- Bank contents need not be cleared; they are unusable because `keys_held`=0.

## Timing
Reset values:
- `key_ready`=1 (IDLE).
- `rk_valid`=0, `rk_last`=0, `rk_idx`=0, `rk_data`=0.
- `keys_held`=0.

Cycles:
- Key accepted at edge E0.
- Edges E1..E10 write rk[1]..rk[10].
- `rk_valid` rises after E10, i.e. expansion latency is 10 cycles.
- With `rk_ready` held high: 11 beats in 11 consecutive cycles. `key_ready` returns to 1 the cycle after the last handshake.
- Replay: `rk_valid` is high the cycle after replay accept.

Outputs:
- `rk_valid`, `rk_idx`, `rk_last` and `key_ready` are registered/state decodes.
- `rk_data` is a bank read (plus the optional transform below); no combinational path from inputs to outputs.
- `rk_ready` may toggle on any cycle; back-pressure stalls stream progress but not correctness.

## Configuration
`AES_EQINV_KEY_EN`
- Defined: when `dir`=1, beats with `rk_idx` 1..9 carry InvMixColumns(rk[idx]) (equivalent-inverse-cipher keys). rk[0] and rk[10] are unmodified; `dir`=0 output is unchanged. The transform sits on the read path only; the bank stays raw.
- Undefined: all beats carry raw rk[idx] regardless of `dir`; no InvMixColumns logic is instantiated.

## Test plan
- **FIPS-197 encrypt order:** `key_in`=2b7e151628aed2a6abf7158809cf4f3c, `dir`=0, `rk_ready`=1.
  - `rk_valid` rises 10 cycles after accept.
  - Beat 0 = key; beat 1 = a0fafe1788542cb123a339392a6c7605; beat 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with `rk_last`=1.
  - `key_ready`=1 on the next cycle.
- **Decrypt order, macro undefined:** same key, `dir`=1.
  - First beat `rk_idx`=10, d014f9a8…0ca6.
  - Beat 9 = ac7766f319fadc2128d12941575c006e.
  - Last beat `rk_idx`=0, equal to the key, `rk_last`=1.
- **Back-pressure:** `rk_ready` random ~50%. Every beat's data/idx/last is held stable until its handshake; exactly 11 handshakes in order; no beat duplicated or skipped.
- **Replay:** after test 1, pulse `replay` with `dir`=1.
  - Stream starts next cycle, with no EXPAND cycles.
  - Contents match test 2.
  - `replay` with `keys_held`=0 after reset produces no `rk_valid`.
- **Reset mid-operation:** assert `rst` at EXPAND r=5, and again mid-STREAM.
  - Next cycle: IDLE, `rk_valid`=0, `keys_held`=0, `key_ready`=1.
  - A new key then expands correctly.
- **`AES_EQINV_KEY_EN` defined, `dir`=1:**
  - Beat idx 9 = InvMixColumns(ac7766f319fadc2128d12941575c006e) per the bench model.
  - idx 10 and 0 are raw.
  - `dir`=0 stream is identical to test 1.

Source files
------------

// File: rtl/aes_key_sched_stream.sv
// AES-128 key schedule: expands one round key per cycle into an 11-entry bank and
// streams it in encrypt or decrypt order. Define AES_EQINV_KEY_EN for equivalent-inverse keys.
module aes_key_sched_stream (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         dir,
  input  logic         replay,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last,
  output logic         keys_held
);

  typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;

  state_t       state, state_nxt;
  logic [3:0]   r, r_prev, p;
  logic         dir_q;
  logic         last_beat;
  logic [127:0] bank [11];
  logic [127:0] rk_next;
  logic [127:0] rd_data;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, aa, bb;
    acc = 8'h00;
    aa  = a;
    bb  = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) acc ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return acc;
  endfunction

  // Forward S-box: multiplicative inverse as x^254 (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, t;
    {w0, w1, w2, w3} = prev;
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    w0 ^= t;
    w1 ^= w0;
    w2 ^= w1;
    w3 ^= w2;
    return {w0, w1, w2, w3};
  endfunction

  always_comb begin
    r_prev  = (r == 4'd0) ? 4'd0 : r - 4'd1;
    rk_next = next_rk(bank[r_prev], rcon(r));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (key_valid)                state_nxt = EXPAND;
        else if (replay && keys_held) state_nxt = STREAM;
      end
      EXPAND:  if (r == 4'd10)             state_nxt = STREAM;
      STREAM:  if (rk_ready && last_beat)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r         <= 4'd0;
      p         <= 4'd0;
      dir_q     <= 1'b0;
      keys_held <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (key_valid) begin
            dir_q     <= dir;
            r         <= 4'd1;
            keys_held <= 1'b0;
          end else if (replay && keys_held) begin
            dir_q <= dir;
            p     <= dir ? 4'd10 : 4'd0;
          end
        end
        EXPAND: begin
          r <= (r == 4'd10) ? 4'd0 : r + 4'd1;
          if (r == 4'd10) begin
            keys_held <= 1'b1;
            p         <= dir_q ? 4'd10 : 4'd0;
          end
        end
        STREAM: begin
          if (rk_ready && !last_beat) p <= dir_q ? p - 4'd1 : p + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the bank is not reset; keys_held=0 after reset keeps stale contents from being streamed.
  always_ff @(posedge clk) begin
    if (state == IDLE && key_valid) bank[0] <= key_in;
    else if (state == EXPAND)       bank[r] <= rk_next;
  end

`ifdef AES_EQINV_KEY_EN
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Decrypt-order middle rounds carry InvMixColumns keys; the bank itself stays raw.
  always_comb begin
    rd_data = bank[p];
    if (dir_q && p != 4'd0 && p != 4'd10)
      rd_data = {inv_mix_col(bank[p][127:96]), inv_mix_col(bank[p][95:64]),
                 inv_mix_col(bank[p][63:32]),  inv_mix_col(bank[p][31:0])};
  end
`else
  assign rd_data = bank[p];
`endif

  always_comb begin
    key_ready = (state == IDLE);
    rk_valid  = (state == STREAM);
    last_beat = dir_q ? (p == 4'd0) : (p == 4'd10);
    rk_last   = rk_valid && last_beat;
    rk_idx    = rk_valid ? p : 4'd0;
    rk_data   = rk_valid ? rd_data : 128'd0;
  end

endmodule

// File: tb/tb_aes_key_sched_stream.sv
// Self-checking bench for aes_key_sched_stream: FIPS-197 vectors, random keys, back-pressure,
// replay and mid-operation reset against a word-level key expansion model.
`timescale 1ns/1ps
module tb_aes_key_sched_stream;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic         dir = 1'b0;
  logic         replay = 1'b0;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic         rk_last;
  logic         keys_held;

  aes_key_sched_stream dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .dir(dir), .replay(replay), .rk_data(rk_data), .rk_idx(rk_idx), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk_last(rk_last), .keys_held(keys_held)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK9 = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [11];
  logic [127:0] cap    [11];
  int           beats = 0;
  bit           exp_dir = 1'b0;
  bit           done = 1'b0;
  bit           rand_ready = 1'b0;
  int           cmp_idx;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, t;
    acc = 8'h00;
    t   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= t;
      t = (t << 1) ^ (t[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // S-box by brute-force inverse search plus bitwise affine transform.
  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^
               inv[(i + 7) % 8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  // FIPS-197 word recurrence over w[0..43].
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = mul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int k = 0; k < 11; k++) exp_rk[k] = {w[4 * k], w[4 * k + 1], w[4 * k + 2], w[4 * k + 3]};
  endtask

  function automatic logic [127:0] imc128(input logic [127:0] v);
    logic [7:0]   base [4];
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] res;
    base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    res  = '0;
    for (int col = 0; col < 4; col++) begin
      for (int j = 0; j < 4; j++) a[j] = v[127 - 32 * col - 8 * j -: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b ^= mul(base[(j - row + 4) % 4], a[j]);
        res[127 - 32 * col - 8 * row -: 8] = b;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] model_beat(input int idx, input bit d);
`ifdef AES_EQINV_KEY_EN
    if (d && idx >= 1 && idx <= 9) return imc128(exp_rk[idx]);
`endif
    return exp_rk[idx];
  endfunction

  // Consumer-side ready pattern, changed just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: every valid cycle must present the model's next beat.
  always @(negedge clk) begin
    if (!rst && rk_valid) begin
      if (beats > 10) begin
        check("extra_beat", 128'(beats), 128'd10);
      end else begin
        cmp_idx = exp_dir ? 10 - beats : beats;
        check("rk_idx", 128'(rk_idx), 128'(cmp_idx));
        check("rk_data", rk_data, model_beat(cmp_idx, exp_dir));
        check("rk_last", 128'(rk_last), 128'(beats == 10));
        check("key_ready_in_stream", 128'(key_ready), 128'd0);
        if (rk_ready) begin
          cap[cmp_idx] = rk_data;
          beats++;
          if (beats == 11) done = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check({name, "_key_ready"}, 128'(key_ready), 128'd1);
    check({name, "_rk_valid"},  128'(rk_valid),  128'd0);
    check({name, "_rk_last"},   128'(rk_last),   128'd0);
    check({name, "_rk_idx"},    128'(rk_idx),    128'd0);
    check({name, "_rk_data"},   rk_data,         128'd0);
    check({name, "_keys_held"}, 128'(keys_held), 128'd0);
  endtask

  task automatic arm_stream(input bit d);
    exp_dir = d;
    beats   = 0;
    done    = 1'b0;
    for (int i = 0; i < 11; i++) cap[i] = '0;
  endtask

  // Returns after the accept edge with the model prepared; measures expansion latency.
  task automatic accept_key(input logic [127:0] key, input bit d);
    int lat;
    model_expand(key);
    arm_stream(d);
    check("key_ready_before_accept", 128'(key_ready), 128'd1);
    key_in    = key;
    dir       = d;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    key_in    = {$urandom, $urandom, $urandom, $urandom};
    dir       = ~d;
    lat = 0;
    forever begin
      @(negedge clk);
      if (lat == 0) begin
        check("expand_key_ready", 128'(key_ready), 128'd0);
        check("expand_keys_held", 128'(keys_held), 128'd0);
      end
      if (rk_valid || lat > 40) break;
      lat++;
    end
    check("expand_latency", 128'(lat), 128'd10);
  endtask

  task automatic finish_stream();
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      #1;
    end
    check("stream_complete", 128'(done), 128'd1);
    @(negedge clk);
    check("post_stream_key_ready", 128'(key_ready), 128'd1);
    check("post_stream_rk_valid",  128'(rk_valid),  128'd0);
    check("post_stream_keys_held", 128'(keys_held), 128'd1);
    check("post_stream_beats",     128'(beats),     128'd11);
  endtask

  task automatic run_key(input logic [127:0] key, input bit d);
    accept_key(key, d);
    finish_stream();
  endtask

  task automatic run_replay(input bit d);
    tick();
    arm_stream(d);
    dir    = d;
    replay = 1'b1;
    tick();
    replay = 1'b0;
    dir    = ~d;
    @(negedge clk);
    check("replay_next_cycle_valid", 128'(rk_valid), 128'd1);
    finish_stream();
  endtask

  task automatic check_decrypt_literals(input string name);
    check({name, "_rk10"}, cap[10], FIPS_RK10);
`ifdef AES_EQINV_KEY_EN
    check({name, "_rk9"}, cap[9], imc128(FIPS_RK9));
`else
    check({name, "_rk9"}, cap[9], FIPS_RK9);
`endif
    check({name, "_rk0"}, cap[0], FIPS_KEY);
  endtask

  initial begin
    build_sbox();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");

    // FIPS-197 encrypt order
    tick();
    run_key(FIPS_KEY, 1'b0);
    check("enc_rk0", cap[0], FIPS_KEY);
    check("enc_rk1", cap[1], FIPS_RK1);
    check("enc_rk10", cap[10], FIPS_RK10);

    // Replay of the stored bank in decrypt order
    run_replay(1'b1);
    check_decrypt_literals("replay_dec");

    // Fresh decrypt-order expansion
    tick();
    run_key(FIPS_KEY, 1'b1);
    check_decrypt_literals("dec");

    // Back-pressure, both orders
    rand_ready = 1'b1;
    tick();
    run_key(FIPS_KEY, 1'b0);
    check("bp_enc_rk1", cap[1], FIPS_RK1);
    run_replay(1'b1);
    check_decrypt_literals("bp_dec");
    rand_ready = 1'b0;

    // Replay with nothing held is ignored
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("reset_after_streams");
    replay = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("replay_without_keys", 128'(rk_valid), 128'd0);
    end
    replay = 1'b0;

    // Reset while expanding (r=5)
    tick();
    model_expand(FIPS_KEY);
    arm_stream(1'b0);
    key_in = FIPS_KEY;
    dir = 1'b0;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("reset_mid_expand");
    tick();
    run_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);

    // Reset while streaming
    tick();
    accept_key({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("reset_mid_stream");
    tick();
    run_key({$urandom, $urandom, $urandom, $urandom}, 1'b1);

    // Random keys, orders, back-pressure and replays
    for (int it = 0; it < 8; it++) begin
      rand_ready = 1'($urandom_range(0, 1));
      tick();
      run_key({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) run_replay(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
